// File: rtl/mc_cpu_pkg.sv
// Shared definitions for the multi-cycle core sequencer: state encoding,
// default reset vector and the wait-state classification helper.
package mc_cpu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_FWAIT = 3'd1,
        ST_EXEC  = 3'd2,
        ST_MEM   = 3'd3,
        ST_MWAIT = 3'd4,
        ST_WB    = 3'd5,
        ST_HALT  = 3'd6
    } state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    // States that wait on a bus handshake and are therefore timeout-guarded.
    function automatic logic is_wait_state(input state_e s);
        return (s == ST_FETCH) || (s == ST_FWAIT) || (s == ST_MEM) || (s == ST_MWAIT);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Handshake wait counter: counts stalled cycles in a wait state and flags the
// cycle in which the stall would reach TIMEOUT.
module mc_wait_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic expire
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Fires in the TIMEOUT-th stalled cycle, so the FSM leaves without an extra cycle.
    assign expire = inc && (cnt_q == CW'(TIMEOUT - 1));

    // NOTE: flops use non-blocking assignments so all of them sample pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mc_cpu_seq.sv
// Multi-cycle core sequencer: fetch / execute / memory / write-back control,
// handshake timeouts, misalignment halt, and cycle/instret counters.
module mc_cpu_seq
    import mc_cpu_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT),
    parameter int                    TIMEOUT    = 255,
    parameter int                    CNT_WIDTH  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  ifu_req_valid,
    input  logic                  ifu_req_ready,
    output logic [DATA_WIDTH-1:0] ifu_req_addr,
    input  logic                  ifu_rsp_valid,
    input  logic [DATA_WIDTH-1:0] ifu_rsp_data,
    output logic [DATA_WIDTH-1:0] instr,
    input  logic                  dec_is_load,
    input  logic                  dec_is_store,
    input  logic                  dec_reg_wr,
    input  logic                  dec_halt,
    input  logic [DATA_WIDTH-1:0] next_pc,
    output logic                  lsu_req_valid,
    input  logic                  lsu_req_ready,
    output logic                  lsu_req_wr,
    input  logic                  lsu_rsp_valid,
    output logic [DATA_WIDTH-1:0] pc,
    output logic                  reg_wr_en,
    output logic                  halted,
    output logic                  fault,
    output logic [CNT_WIDTH-1:0]  cycle_cnt,
    output logic [CNT_WIDTH-1:0]  instret_cnt
);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] ir_q, ir_d;
    logic                  fault_q, fault_d;
    logic [CNT_WIDTH-1:0]  cycle_q, cycle_d;
    logic [CNT_WIDTH-1:0]  instret_q, instret_d;

    logic exit_evt;
    logic wait_inc;
    logic wait_clear;
    logic wait_expire;
    logic pc_aligned;

    assign pc_aligned = (next_pc[1:0] == 2'b00);

    // Handshake that ends the current wait state.
    always_comb begin
        exit_evt = 1'b0;
        case (state_q)
            ST_FETCH: exit_evt = ifu_req_ready;
            ST_FWAIT: exit_evt = ifu_rsp_valid;
            ST_MEM:   exit_evt = lsu_req_ready;
            ST_MWAIT: exit_evt = lsu_rsp_valid;
            default:  exit_evt = 1'b0;
        endcase
    end

    assign wait_inc   = is_wait_state(state_q) && !exit_evt;
    assign wait_clear = (state_d != state_q);

    mc_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (wait_clear),
        .inc    (wait_inc),
        .expire (wait_expire)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        fault_d   = fault_q;
        instret_d = instret_q;
        cycle_d   = cycle_q + CNT_WIDTH'(1);
        case (state_q)
            ST_FETCH: if (exit_evt) state_d = ST_FWAIT;
            ST_FWAIT: begin
                if (exit_evt) begin
                    ir_d    = ifu_rsp_data;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (dec_halt) begin
                    state_d = ST_HALT;
                end else if (dec_is_load || dec_is_store) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM:   if (exit_evt) state_d = ST_MWAIT;
            ST_MWAIT: if (exit_evt) state_d = ST_WB;
            ST_WB: begin
                if (pc_aligned) begin
                    pc_d      = next_pc;
                    instret_d = instret_q + CNT_WIDTH'(1);
                    state_d   = ST_FETCH;
                end else begin
                    fault_d = 1'b1;
                    state_d = ST_HALT;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_HALT;
        endcase
        if (wait_expire) begin
            fault_d = 1'b1;
            state_d = ST_HALT;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            fault_q   <= 1'b0;
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            fault_q   <= fault_d;
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    // Strobes are gated by rst so nothing is requested while reset is held.
    assign ifu_req_valid = rst && (state_q == ST_FETCH);
    assign lsu_req_valid = rst && (state_q == ST_MEM);
    assign lsu_req_wr    = rst && (state_q == ST_MEM) && dec_is_store;
    assign reg_wr_en     = rst && (state_q == ST_WB) && pc_aligned && dec_reg_wr && !dec_is_store;

    assign ifu_req_addr = pc_q;
    assign pc           = pc_q;
    assign instr        = ir_q;
    assign halted       = (state_q == ST_HALT);
    assign fault        = fault_q;
    assign cycle_cnt    = cycle_q;
    assign instret_cnt  = instret_q;

endmodule

// File: tb/tb_mc_cpu_seq.sv
// Self-checking bench for mc_cpu_seq: randomized bus latencies checked against
// a per-instruction latency/retire model kept in the bench.
module tb_mc_cpu_seq;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam int          TMO    = 8;

    logic        clk;
    logic        rst;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_req_addr;
    logic        ifu_rsp_valid;
    logic [31:0] ifu_rsp_data;
    logic [31:0] instr;
    logic        dec_is_load;
    logic        dec_is_store;
    logic        dec_reg_wr;
    logic        dec_halt;
    logic [31:0] next_pc;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic        lsu_req_wr;
    logic        lsu_rsp_valid;
    logic [31:0] pc;
    logic        reg_wr_en;
    logic        halted;
    logic        fault;
    logic [7:0]  cycle_cnt;
    logic [7:0]  instret_cnt;

    int          checks      = 0;
    int          failures    = 0;
    int          cyc_model   = 0;
    int          exp_instret = 0;
    logic [31:0] exp_pc      = RST_PC;

    mc_cpu_seq #(
        .TIMEOUT   (TMO),
        .CNT_WIDTH (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_req_addr  (ifu_req_addr),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_data  (ifu_rsp_data),
        .instr         (instr),
        .dec_is_load   (dec_is_load),
        .dec_is_store  (dec_is_store),
        .dec_reg_wr    (dec_reg_wr),
        .dec_halt      (dec_halt),
        .next_pc       (next_pc),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_req_wr    (lsu_req_wr),
        .lsu_rsp_valid (lsu_rsp_valid),
        .pc            (pc),
        .reg_wr_en     (reg_wr_en),
        .halted        (halted),
        .fault         (fault),
        .cycle_cnt     (cycle_cnt),
        .instret_cnt   (instret_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ends the current cycle; the model counts every edge taken out of reset.
    task automatic step();
        if (rst) cyc_model++;
        else     cyc_model = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        lsu_req_ready = 1'b0;
        lsu_rsp_valid = 1'b0;
        ifu_rsp_data  = $urandom;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        step();
        step();
        rst         = 1'b1;
        exp_pc      = RST_PC;
        exp_instret = 0;
        #1;
    endtask

    // Plays memory for one instruction. ends: 0 retire, 1 misaligned halt, 2 dec_halt.
    // The window length is the model latency; afterwards the core must be in its end state.
    task automatic run_instr(input string tag, input int kind, input int ends,
                             input int fr, input int fd, input int lr, input int ld,
                             input logic [31:0] word, input logic [31:0] npc, input logic rw);
        int lat, phase, cnt, ifu_cycles, lsu_cycles, wr_pulses, wr_at, bad_wr, exp_lsu;
        bit is_mem, exp_wr;
        is_mem = (kind != 0);
        lat = (ends == 2) ? 3 + fr + fd : 4 + fr + fd + (is_mem ? 2 + lr + ld : 0);
        dec_is_load  = (kind == 1);
        dec_is_store = (kind == 2);
        dec_reg_wr   = rw;
        dec_halt     = (ends == 2);
        next_pc      = npc;
        phase = 0; cnt = 0; ifu_cycles = 0; lsu_cycles = 0; wr_pulses = 0; wr_at = -1; bad_wr = 0;
        for (int c = 1; c <= lat; c++) begin
            idle_inputs();
            if (ifu_req_valid) ifu_cycles++;
            if (lsu_req_valid) begin
                lsu_cycles++;
                if (lsu_req_wr !== (kind == 2)) bad_wr++;
            end
            case (phase)
                0: if (ifu_req_valid) begin
                    if (cnt == fr) begin
                        ifu_req_ready = 1'b1;
                        ifu_rsp_valid = 1'($urandom_range(0, 1));
                        phase = 1; cnt = 0;
                    end else cnt++;
                end
                1: if (cnt == fd) begin
                    ifu_rsp_valid = 1'b1;
                    ifu_rsp_data  = word;
                    phase = is_mem ? 2 : 4; cnt = 0;
                end else cnt++;
                2: if (lsu_req_valid) begin
                    if (cnt == lr) begin
                        lsu_req_ready = 1'b1;
                        phase = 3; cnt = 0;
                    end else cnt++;
                end
                3: if (cnt == ld) begin
                    lsu_rsp_valid = 1'b1;
                    phase = 4;
                end else cnt++;
                default: ;
            endcase
            #1;
            if (reg_wr_en) begin
                wr_pulses++;
                wr_at = c;
            end
            step();
        end
        idle_inputs();
        #1;
        if (ends == 0) begin
            exp_pc = npc;
            exp_instret++;
        end
        exp_wr  = (ends == 0) && rw && (kind != 2);
        exp_lsu = (is_mem && ends != 2) ? lr + 1 : 0;
        checks++; if (halted !== (ends != 0)) begin failures++; $display("FAIL %s halted: got %b exp %b", tag, halted, ends != 0); end
        checks++; if (fault !== (ends == 1)) begin failures++; $display("FAIL %s fault: got %b exp %b", tag, fault, ends == 1); end
        checks++; if (ifu_req_valid !== (ends == 0)) begin failures++; $display("FAIL %s next_fetch: got %b exp %b", tag, ifu_req_valid, ends == 0); end
        checks++; if (pc !== exp_pc) begin failures++; $display("FAIL %s pc: got %h exp %h", tag, pc, exp_pc); end
        checks++; if (ifu_req_addr !== exp_pc) begin failures++; $display("FAIL %s ifu_req_addr: got %h exp %h", tag, ifu_req_addr, exp_pc); end
        checks++; if (instr !== word) begin failures++; $display("FAIL %s instr: got %h exp %h", tag, instr, word); end
        checks++; if (instret_cnt !== exp_instret[7:0]) begin failures++; $display("FAIL %s instret: got %0d exp %0d", tag, instret_cnt, exp_instret[7:0]); end
        checks++; if (cycle_cnt !== cyc_model[7:0]) begin failures++; $display("FAIL %s cycle_cnt: got %0d exp %0d", tag, cycle_cnt, cyc_model[7:0]); end
        checks++; if (wr_pulses !== (exp_wr ? 1 : 0)) begin failures++; $display("FAIL %s reg_wr_pulses: got %0d exp %0d", tag, wr_pulses, exp_wr ? 1 : 0); end
        if (exp_wr) begin
            checks++; if (wr_at !== lat) begin failures++; $display("FAIL %s retire_cycle: got %0d exp %0d", tag, wr_at, lat); end
        end
        checks++; if (ifu_cycles !== fr + 1) begin failures++; $display("FAIL %s ifu_req_cycles: got %0d exp %0d", tag, ifu_cycles, fr + 1); end
        checks++; if (lsu_cycles !== exp_lsu) begin failures++; $display("FAIL %s lsu_req_cycles: got %0d exp %0d", tag, lsu_cycles, exp_lsu); end
        checks++; if (bad_wr !== 0) begin failures++; $display("FAIL %s lsu_req_wr: got %0d bad cycles exp 0", tag, bad_wr); end
    endtask

    // Sits in HALT with random bus activity; nothing may move except cycle_cnt.
    task automatic test_halt_hold(input string tag, input int n);
        int reqs, wrs;
        logic [31:0] pc0, ir0;
        logic [7:0] ir_cnt0;
        logic fault0;
        reqs = 0; wrs = 0;
        pc0 = pc; ir0 = instr; ir_cnt0 = instret_cnt; fault0 = fault;
        for (int c = 0; c < n; c++) begin
            ifu_req_ready = 1'($urandom); ifu_rsp_valid = 1'($urandom);
            lsu_req_ready = 1'($urandom); lsu_rsp_valid = 1'($urandom);
            ifu_rsp_data  = $urandom;
            #1;
            if (ifu_req_valid || lsu_req_valid) reqs++;
            if (reg_wr_en) wrs++;
            step();
        end
        idle_inputs();
        #1;
        checks++; if (reqs !== 0) begin failures++; $display("FAIL %s halt_requests: got %0d exp 0", tag, reqs); end
        checks++; if (wrs !== 0) begin failures++; $display("FAIL %s halt_writes: got %0d exp 0", tag, wrs); end
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL %s halt_sticky: got %b exp 1", tag, halted); end
        checks++; if (fault !== fault0) begin failures++; $display("FAIL %s fault_sticky: got %b exp %b", tag, fault, fault0); end
        checks++; if (pc !== pc0) begin failures++; $display("FAIL %s halt_pc: got %h exp %h", tag, pc, pc0); end
        checks++; if (instr !== ir0) begin failures++; $display("FAIL %s halt_ir: got %h exp %h", tag, instr, ir0); end
        checks++; if (instret_cnt !== ir_cnt0) begin failures++; $display("FAIL %s halt_instret: got %0d exp %0d", tag, instret_cnt, ir_cnt0); end
        checks++; if (cycle_cnt !== cyc_model[7:0]) begin failures++; $display("FAIL %s halt_cycle_cnt: got %0d exp %0d", tag, cycle_cnt, cyc_model[7:0]); end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ifu_req_ready = 1'b1; ifu_rsp_valid = 1'b1; lsu_req_ready = 1'b1; lsu_rsp_valid = 1'b1;
        ifu_rsp_data = $urandom; next_pc = RST_PC + 32'd4;
        dec_is_load = 1'b0; dec_is_store = 1'b1; dec_reg_wr = 1'b1; dec_halt = 1'b0;
        step();
        step();
        checks++; if (ifu_req_valid !== 1'b0) begin failures++; $display("FAIL reset ifu_req_valid: got %b exp 0", ifu_req_valid); end
        checks++; if (lsu_req_valid !== 1'b0 || lsu_req_wr !== 1'b0) begin failures++; $display("FAIL reset lsu_req: got %b%b exp 00", lsu_req_valid, lsu_req_wr); end
        checks++; if (reg_wr_en !== 1'b0) begin failures++; $display("FAIL reset reg_wr_en: got %b exp 0", reg_wr_en); end
        checks++; if (pc !== RST_PC) begin failures++; $display("FAIL reset pc: got %h exp %h", pc, RST_PC); end
        checks++; if (instr !== 32'd0) begin failures++; $display("FAIL reset instr: got %h exp 0", instr); end
        checks++; if (cycle_cnt !== 8'd0 || instret_cnt !== 8'd0) begin failures++; $display("FAIL reset counters: got %0d/%0d exp 0/0", cycle_cnt, instret_cnt); end
        checks++; if (halted !== 1'b0 || fault !== 1'b0) begin failures++; $display("FAIL reset flags: got %b%b exp 00", halted, fault); end
        idle_inputs();
        rst = 1'b1;
        exp_pc = RST_PC;
        exp_instret = 0;
        #1;
        checks++; if (ifu_req_valid !== 1'b1) begin failures++; $display("FAIL reset first_fetch: got %b exp 1", ifu_req_valid); end
    endtask

    task automatic test_random(input string tag, input int n, input int max_dly);
        int kind;
        logic [31:0] npc;
        for (int i = 0; i < n; i++) begin
            kind = int'($urandom_range(0, 2));
            npc  = exp_pc + 32'(4 * $urandom_range(0, 15));
            run_instr(tag, kind, 0,
                      int'($urandom_range(0, max_dly)), int'($urandom_range(0, max_dly)),
                      int'($urandom_range(0, max_dly)), int'($urandom_range(0, max_dly)),
                      $urandom, npc, 1'($urandom));
        end
    endtask

    task automatic test_timeout();
        int reqs_after;
        reqs_after = 0;
        do_reset();
        dec_is_load = 1'b0; dec_is_store = 1'b0; dec_reg_wr = 1'b0; dec_halt = 1'b0;
        for (int c = 1; c <= 1 + TMO; c++) begin
            idle_inputs();
            ifu_req_ready = (c == 1);
            #1;
            if (c > 1 && ifu_req_valid) reqs_after++;
            if (c == 1 + TMO) begin
                checks++; if (halted !== 1'b0) begin failures++; $display("FAIL timeout early_halt: got %b exp 0", halted); end
            end
            step();
        end
        checks++; if (halted !== 1'b1 || fault !== 1'b1) begin failures++; $display("FAIL timeout halt_fault: got %b%b exp 11", halted, fault); end
        checks++; if (reqs_after !== 0) begin failures++; $display("FAIL timeout refetch: got %0d exp 0", reqs_after); end
        checks++; if (pc !== RST_PC) begin failures++; $display("FAIL timeout pc: got %h exp %h", pc, RST_PC); end
        test_halt_hold("timeout_hold", 20);
    endtask

    task automatic test_reset_mwait();
        logic [31:0] w;
        w = $urandom;
        do_reset();
        dec_is_load = 1'b1; dec_is_store = 1'b0; dec_reg_wr = 1'b1; dec_halt = 1'b0;
        next_pc = RST_PC + 32'd4;
        idle_inputs(); ifu_req_ready = 1'b1; step();
        idle_inputs(); ifu_rsp_valid = 1'b1; ifu_rsp_data = w; step();
        idle_inputs(); step();
        idle_inputs(); lsu_req_ready = 1'b1; #1;
        checks++; if (lsu_req_valid !== 1'b1) begin failures++; $display("FAIL rst_mwait lsu_req_valid: got %b exp 1", lsu_req_valid); end
        step();
        idle_inputs(); step();
        rst = 1'b0; step();
        checks++; if (ifu_req_valid !== 1'b0 || pc !== RST_PC) begin failures++; $display("FAIL rst_mwait in_reset: got req=%b pc=%h exp req=0 pc=%h", ifu_req_valid, pc, RST_PC); end
        rst = 1'b1;
        lsu_rsp_valid = 1'b1; ifu_rsp_valid = 1'b1; ifu_rsp_data = ~w;
        #1;
        checks++; if (reg_wr_en !== 1'b0) begin failures++; $display("FAIL rst_mwait stale_write: got %b exp 0", reg_wr_en); end
        checks++; if (ifu_req_valid !== 1'b1) begin failures++; $display("FAIL rst_mwait fetch: got %b exp 1", ifu_req_valid); end
        step();
        step();
        checks++; if (ifu_req_valid !== 1'b1 || instr !== 32'd0) begin failures++; $display("FAIL rst_mwait stale_rsp: got req=%b ir=%h exp req=1 ir=0", ifu_req_valid, instr); end
        checks++; if (instret_cnt !== 8'd0 || pc !== RST_PC) begin failures++; $display("FAIL rst_mwait state: got instret=%0d pc=%h exp 0 %h", instret_cnt, pc, RST_PC); end
        idle_inputs();
        exp_pc = RST_PC;
        exp_instret = 0;
        run_instr("rst_mwait_next", 0, 0, 0, 0, 0, 0, $urandom, RST_PC + 32'd8, 1'b1);
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        dec_is_load = 1'b0; dec_is_store = 1'b0; dec_reg_wr = 1'b0; dec_halt = 1'b0;
        next_pc = '0;

        test_reset();
        run_instr("alu_zero_wait", 0, 0, 0, 0, 0, 0, $urandom, RST_PC + 32'd4, 1'b1);
        run_instr("load_stall", 1, 0, 0, 0, 3, 0, $urandom, exp_pc + 32'd4, 1'b1);
        run_instr("store", 2, 0, 0, 0, 1, 1, $urandom, exp_pc + 32'd4, 1'b1);
        test_random("random", 30, 4);
        test_random("back_to_back", 260, 0);

        do_reset();
        run_instr("dec_halt", 1, 2, 1, 1, 0, 0, $urandom, RST_PC + 32'd4, 1'b1);
        test_halt_hold("dec_halt_hold", 10);

        do_reset();
        run_instr("misaligned", 0, 1, 0, 0, 0, 0, $urandom, RST_PC + 32'd2, 1'b1);
        test_halt_hold("misaligned_hold", 300);

        test_timeout();
        test_reset_mwait();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_cpu_seq.md
MC_CPU_SEQ -- requirements
Module: mc_cpu_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of PC, instruction, addresses.
REQ-002 SHALL have parameter RESET_PC, default 32'h8000_0000: first fetch address.
REQ-003 SHALL have parameter TIMEOUT, default 255: maximum wait cycles per bus handshake phase before fault.
REQ-004 SHALL have parameter CNT_WIDTH, default 64: width of the cycle and instret counters.
REQ-005 SHALL have ports, clock and reset first:
- clk  in  1  rising-edge clock.
- rst  in  1  one clock; reset is synchronous and active-low.
- ifu_req_valid  out  1  fetch request.
- ifu_req_ready  in  1  fetch request accepted.
- ifu_req_addr  out  DATA_WIDTH  fetch address (= pc).
- ifu_rsp_valid  in  1  fetch data valid.
- ifu_rsp_data  in  DATA_WIDTH  fetched instruction.
- instr  out  DATA_WIDTH  instruction register (IR).
- dec_is_load  in  1  decoded IR is a load.
- dec_is_store  in  1  decoded IR is a store.
- dec_reg_wr  in  1  decoded IR writes rd.
- dec_halt  in  1  ebreak or illegal instruction.
- next_pc  in  DATA_WIDTH  datapath-computed successor PC.
- lsu_req_valid  out  1  data-memory request.
- lsu_req_ready  in  1  data request accepted.
- lsu_req_wr  out  1  1 = store, 0 = load.
- lsu_rsp_valid  in  1  load data or store ack valid.
- pc  out  DATA_WIDTH  current PC.
- reg_wr_en  out  1  register-file write strobe.
- halted  out  1  core stopped (sticky).
- fault  out  1  stop was caused by timeout or misalignment (sticky).
- cycle_cnt  out  CNT_WIDTH  cycles since reset.
- instret_cnt  out  CNT_WIDTH  retired instructions.

Function
REQ-006 SHALL implement states FETCH, FWAIT, EXEC, MEM, MWAIT, WB, HALT.
REQ-007 FETCH: ifu_req_valid=1; on ifu_req_ready -> FWAIT.
REQ-008 FWAIT: on ifu_rsp_valid latch ifu_rsp_data into IR -> EXEC; rsp in the same cycle as req accept is ignored.
REQ-009 EXEC, one cycle: dec_halt -> HALT (fault=0); else load/store -> MEM; else -> WB.
REQ-010 MEM: lsu_req_valid=1, lsu_req_wr=dec_is_store; on lsu_req_ready -> MWAIT.
REQ-011 MWAIT: on lsu_rsp_valid -> WB.
REQ-012 WB, one cycle: reg_wr_en = dec_reg_wr & ~dec_is_store; pc <= next_pc; instret_cnt += 1; -> FETCH.
REQ-013 reg_wr_en SHALL be 0 in every state except WB.
REQ-014 Request valids SHALL be Moore outputs, held until ready; no request in any other state.
REQ-015 Wait counter: cleared on entry to FETCH, FWAIT, MEM, MWAIT; increments each cycle in those states without the exit event; reaching TIMEOUT -> HALT, fault=1.
REQ-016 In WB, next_pc[1:0] != 0 -> pc unchanged, no retire, no write, -> HALT, fault=1.
REQ-017 HALT is absorbing until reset; no requests; pc, IR, instret_cnt frozen; cycle_cnt continues.
REQ-018 Counters SHALL wrap modulo 2^CNT_WIDTH.
REQ-019 Zero-wait memory (ready with valid, rsp next cycle): ALU instruction = 4 cycles, load/store = 6 cycles.

Reset
REQ-020 While rst=0 at a clock edge: state=FETCH, pc=RESET_PC, IR=0, counters=0, halted=0, fault=0, all request outputs and reg_wr_en=0.
REQ-021 Reset mid-transaction SHALL abandon the outstanding request; a late response after reset release, while in FETCH, SHALL be ignored.
REQ-022 First ifu_req_valid SHALL assert in the first cycle after rst returns high.

Structure
REQ-023 State encoding enum and RESET_PC default SHALL live in a shared core package.
REQ-024 Wait/timeout counter SHALL be a sub-module named mc_wait_timer.

Verification
REQ-025 Zero-wait fetch of ALU op, next_pc=pc+4 -> retire at cycle 4, pc=0x8000_0004, reg_wr_en one pulse, instret_cnt=1.
REQ-026 Load with lsu_req_ready held low 3 cycles -> MEM for 4 cycles, retire at cycle 9, one reg_wr_en pulse.
REQ-027 Store -> lsu_req_wr=1, reg_wr_en stays 0, instret_cnt increments.
REQ-028 ifu_rsp_valid never asserted, TIMEOUT=8 -> HALT with fault=1 after 8 FWAIT cycles; no further requests.
REQ-029 next_pc=0x8000_0002 -> HALT, fault=1, pc unchanged, instret_cnt unchanged.
REQ-030 rst low during MWAIT, stale lsu_rsp_valid after release -> pc=0x8000_0000, state FETCH, no reg_wr_en.
